// File: rtl/playback_pkg.sv
// Shared definitions for the playback scheduler: state codes, mode codes,
// song codes and the playlist wrap helper.
package playback_pkg;

  // Scheduler states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  // Repeat modes, sampled only when the player reports song_done
  localparam logic [1:0] MODE_SINGLE      = 2'b00;
  localparam logic [1:0] MODE_REPEAT_ONE  = 2'b01;
  localparam logic [1:0] MODE_LIST_ONCE   = 2'b10;
  localparam logic [1:0] MODE_LIST_REPEAT = 2'b11;

  // Song select codes; SONG_NONE silences and resets the player
  localparam logic [1:0] SONG_NONE = 2'b00;
  localparam logic [1:0] SONG_LS   = 2'b01;
  localparam logic [1:0] SONG_HB   = 2'b10;
  localparam logic [1:0] SONG_JB   = 2'b11;

  // Step one song forward or backward, wrapping between SONG_LS and last
  function automatic logic [1:0] song_wrap(input logic [1:0] cur,
                                           input logic       fwd,
                                           input logic [1:0] last);
    if (fwd) return (cur >= last) ? SONG_LS : cur + 2'd1;
    else     return (cur <= SONG_LS) ? last : cur - 2'd1;
  endfunction

endpackage

// File: rtl/gap_timer.sv
// Down-counter that times the silent gap between songs. Loads LOAD_VAL,
// counts down to zero and parks there; clear forces it back to zero.
module gap_timer
  import playback_pkg::*;
#(
  parameter int          CNT_W    = 32,
  parameter logic [CNT_W-1:0] LOAD_VAL = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clear,
  output logic zero
);

  logic [CNT_W-1:0] cnt;

  // Clear beats load; otherwise count down until zero and hold there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (clear)        cnt <= '0;
    else if (load)         cnt <= LOAD_VAL;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/playback_scheduler.sv
// Top-level play/pause/next/prev/stop sequencer for the multi-song player.
// All outputs are registered from the next-state values so each update
// shows one clock after the pulse that caused it.
module playback_scheduler
  import playback_pkg::*;
#(
  parameter int NUM_SONGS  = 3,
  parameter int GAP_CYCLES = 25_000_000,
  parameter int CNT_W      = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_play,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_stop,
  input  logic [1:0] mode,
  input  logic       song_done,
  output logic [1:0] n_th_song,
  output logic       hold,
  output logic       playing,
  output logic [1:0] song_sel
);

  localparam logic [1:0]       LAST_SONG = NUM_SONGS[1:0];
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  // Current FSM state, kept as a named signal for checkers to bind to
  logic [1:0] state;
  logic [1:0] cur_song;
  logic [1:0] nxt_state;
  logic [1:0] nxt_song;
  logic       gap_load;
  logic       gap_clear;
  logic       gap_zero;
  logic       btn_step;
  logic [1:0] stepped_song;

  // next wins over prev when both arrive together
  assign btn_step     = btn_next | btn_prev;
  assign stepped_song = song_wrap(cur_song, btn_next, LAST_SONG);

  gap_timer #(
    .CNT_W    (CNT_W),
    .LOAD_VAL (GAP_LOAD)
  ) u_gap_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (gap_load),
    .clear (gap_clear),
    .zero  (gap_zero)
  );

  // Next state and song; priority stop > next > prev > play > song_done
  always_comb begin
    nxt_state = state;
    nxt_song  = cur_song;
    gap_load  = 1'b0;
    gap_clear = 1'b0;
    case (state)
      ST_IDLE: begin
        if (btn_stop)      nxt_state = ST_IDLE;
        else if (btn_step) nxt_song  = stepped_song;
        else if (btn_play) nxt_state = ST_PLAY;
      end
      ST_PLAY: begin
        if (btn_stop) begin
          nxt_state = ST_IDLE;
          gap_clear = 1'b1;
        end else if (btn_step) begin
          nxt_song  = stepped_song;
          nxt_state = ST_GAP;
          gap_load  = 1'b1;
        end else if (btn_play) begin
          nxt_state = ST_PAUSE;
        end else if (song_done) begin
          case (mode)
            MODE_SINGLE: nxt_state = ST_IDLE;
            MODE_REPEAT_ONE: begin
              nxt_state = ST_GAP;
              gap_load  = 1'b1;
            end
            MODE_LIST_ONCE: begin
              if (cur_song == LAST_SONG) begin
                nxt_state = ST_IDLE;
              end else begin
                nxt_song  = song_wrap(cur_song, 1'b1, LAST_SONG);
                nxt_state = ST_GAP;
                gap_load  = 1'b1;
              end
            end
            default: begin
              nxt_song  = song_wrap(cur_song, 1'b1, LAST_SONG);
              nxt_state = ST_GAP;
              gap_load  = 1'b1;
            end
          endcase
        end
      end
      ST_PAUSE: begin
        if (btn_stop) begin
          nxt_state = ST_IDLE;
          gap_clear = 1'b1;
        end else if (btn_step) begin
          nxt_song  = stepped_song;
          nxt_state = ST_GAP;
          gap_load  = 1'b1;
        end else if (btn_play) begin
          nxt_state = ST_PLAY;
        end
      end
      default: begin
        // ST_GAP: play and song_done are ignored; next/prev restart the gap
        if (btn_stop) begin
          nxt_state = ST_IDLE;
          gap_clear = 1'b1;
        end else if (btn_step) begin
          nxt_song = stepped_song;
          gap_load = 1'b1;
        end else if (gap_zero) begin
          nxt_state = ST_PLAY;
        end
      end
    endcase
  end

  // State, song index and registered player-facing outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cur_song  <= SONG_LS;
      n_th_song <= SONG_NONE;
      hold      <= 1'b0;
      playing   <= 1'b0;
      song_sel  <= SONG_LS;
    end else begin
      state     <= nxt_state;
      cur_song  <= nxt_song;
      n_th_song <= (nxt_state == ST_PLAY || nxt_state == ST_PAUSE) ? nxt_song : SONG_NONE;
      hold      <= (nxt_state == ST_PAUSE);
      playing   <= (nxt_state == ST_PLAY);
      song_sel  <= nxt_song;
    end
  end

endmodule

// File: tb/tb_playback_scheduler.sv
// Directed bench for playback_scheduler with GAP_CYCLES=4, NUM_SONGS=3.
module tb_playback_scheduler;

  localparam int G  = 4;
  localparam int NS = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_play = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_prev = 1'b0;
  logic       btn_stop = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       song_done = 1'b0;
  logic [1:0] n_th_song;
  logic       hold;
  logic       playing;
  logic [1:0] song_sel;

  // Clock
  always #5 clk = ~clk;

  playback_scheduler #(
    .NUM_SONGS  (NS),
    .GAP_CYCLES (G),
    .CNT_W      (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_play  (btn_play),
    .btn_next  (btn_next),
    .btn_prev  (btn_prev),
    .btn_stop  (btn_stop),
    .mode      (mode),
    .song_done (song_done),
    .n_th_song (n_th_song),
    .hold      (hold),
    .playing   (playing),
    .song_sel  (song_sel)
  );

  int checks = 0;
  int failures = 0;

  // Expected output tuple per clock: {n_th_song, hold, playing, song_sel}
  logic [5:0] exp_q[$];
  logic [5:0] exp_now;

  // Player model: what the listener hears, in plain terms
  string m_phase = "idle";
  int    m_song  = 1;
  int    m_silent_left = 0;

  function automatic int wrap(input int s, input bit fwd);
    if (fwd) return (s == NS) ? 1 : s + 1;
    else     return (s == 1) ? NS : s - 1;
  endfunction

  function automatic logic [5:0] model_out();
    logic [1:0] s;
    logic [1:0] n;
    s = 2'(m_song);
    n = (m_phase == "play" || m_phase == "pause") ? s : 2'b00;
    return {n, (m_phase == "pause"), (m_phase == "play"), s};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t: got n_th=%b hold=%b playing=%b sel=%b, want n_th=%b hold=%b playing=%b sel=%b",
               name, $time, act[5:4], act[3], act[2], act[1:0], exp[5:4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  // Advance the model by one clock given this clock's pulses
  task automatic model_step(input bit p, input bit n, input bit pv, input bit s, input bit d);
    if (s) begin
      m_phase = "idle";
      m_silent_left = 0;
    end else if (n || pv) begin
      m_song = wrap(m_song, n);
      if (m_phase != "idle") begin
        m_phase = "gap";
        m_silent_left = G - 1;
      end
    end else if (m_phase == "gap") begin
      if (m_silent_left == 0) m_phase = "play";
      else m_silent_left--;
    end else if (p) begin
      if (m_phase == "idle" || m_phase == "pause") m_phase = "play";
      else m_phase = "pause";
    end else if (d && m_phase == "play") begin
      case (mode)
        2'b00: m_phase = "idle";
        2'b01: begin m_phase = "gap"; m_silent_left = G - 1; end
        2'b10: begin
          if (m_song == NS) m_phase = "idle";
          else begin m_song = m_song + 1; m_phase = "gap"; m_silent_left = G - 1; end
        end
        default: begin m_song = wrap(m_song, 1'b1); m_phase = "gap"; m_silent_left = G - 1; end
      endcase
    end
    exp_q.push_back(model_out());
  endtask

  // Driver: one clock of pulses, applied on the falling edge
  task automatic cyc(input bit p, input bit n, input bit pv, input bit s, input bit d);
    @(negedge clk);
    btn_play  = p;
    btn_next  = n;
    btn_prev  = pv;
    btn_stop  = s;
    song_done = d;
    model_step(p, n, pv, s, d);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0);
  endtask

  // Hand-computed expectation on the output just after the next rising edge
  task automatic lit(input string name, input logic [5:0] exp);
    @(posedge clk);
    #2;
    check(name, {n_th_song, hold, playing, song_sel}, exp);
  endtask

  // Scoreboard: compare every updated cycle against the model
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_now = exp_q.pop_front();
      check("cycle", {n_th_song, hold, playing, song_sel}, exp_now);
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    #12;
    check("reset_values", {n_th_song, hold, playing, song_sel}, {2'b00, 1'b0, 1'b0, 2'b01});
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    cyc(1, 0, 0, 0, 0);
    lit("play_start", {2'b01, 1'b0, 1'b1, 2'b01});
    cyc(0, 1, 0, 0, 0);                          // to song 2 through gap
    idle(5);
    cyc(1, 0, 0, 0, 0);
    lit("pause_song2", {2'b10, 1'b1, 1'b0, 2'b10});
    idle(2);
    cyc(1, 0, 0, 0, 0);
    lit("resume_song2", {2'b10, 1'b0, 1'b1, 2'b10});

    cyc(0, 1, 0, 0, 0);                          // song 3
    idle(5);
    cyc(0, 1, 0, 0, 0);                          // 3 wraps to 1
    idle(4);
    lit("next_wrap_play", {2'b01, 1'b0, 1'b1, 2'b01});

    mode = 2'b01;
    cyc(0, 0, 0, 0, 1);
    idle(4);
    lit("repeat_one", {2'b01, 1'b0, 1'b1, 2'b01});

    cyc(0, 0, 1, 0, 0);                          // prev 1 wraps to 3
    idle(4);
    mode = 2'b10;
    cyc(0, 0, 0, 0, 1);
    lit("list_once_end", {2'b00, 1'b0, 1'b0, 2'b11});
    idle(1);

    cyc(1, 0, 0, 0, 0);
    mode = 2'b11;
    cyc(0, 0, 0, 0, 1);                          // 3 wraps to 1 through gap
    idle(4);

    cyc(0, 1, 0, 1, 1);
    lit("stop_priority", {2'b00, 1'b0, 1'b0, 2'b01});
    cyc(0, 0, 1, 0, 0);
    lit("prev_in_idle", {2'b00, 1'b0, 1'b0, 2'b11});
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);

    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);                          // next beats play
    cyc(1, 0, 0, 0, 0);                          // ignored in gap
    idle(1);
    cyc(0, 1, 0, 0, 0);                          // reload gap, song 3
    idle(4);
    lit("gap_reload", {2'b11, 1'b0, 1'b1, 2'b11});

    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);                          // ignored in pause
    cyc(0, 0, 1, 0, 0);
    lit("prev_from_pause", {2'b00, 1'b0, 1'b0, 2'b10});
    idle(4);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);                          // prev beats play
    idle(4);

    cyc(0, 1, 0, 0, 0);
    idle(1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {n_th_song, hold, playing, song_sel}, {2'b00, 1'b0, 1'b0, 2'b01});
    m_phase = "idle";
    m_song = 1;
    m_silent_left = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 0, 0, 0);
    lit("play_after_reset", {2'b01, 1'b0, 1'b1, 2'b01});
    idle(3);
    @(posedge clk);
    #3;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
